// File: rtl/spart_tx_fifo.sv
// SPART transmitter with a FIFO_DEPTH-entry transmit queue and back-to-back framing.
// Define SPART_TX_PARITY_EN to insert a parity bit after the data bits.
module spart_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          tx_write,
  input  logic [DATA_W-1:0]             tx_data,
  input  logic                          parity_odd,
  output logic                          TBR,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          tx_overflow,
  output logic                          TX
);

`ifdef SPART_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int FRAME_BITS = 1 + DATA_W + PAR_BITS + STOP_BITS;
  localparam int SHIFT_W    = FRAME_BITS - 1;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = PTR_W + 1;
  localparam int TICK_W     = $clog2(OVERSAMPLE);
  localparam int BIT_W      = $clog2(FRAME_BITS);

  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0]  COUNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ALIGN,
    S_SHIFT
  } state_t;

  // ---------------------------------------------------------------------------
  // Transmit queue
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic              ovf_q;
  logic              full;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] head;

  assign full = (count_q == COUNT_FULL);
  assign push = tx_write && !full;
  assign head = mem[rd_ptr];

  // NOTE: storage needs no reset; the pointers and count define what is valid,
  // so clearing them flushes the queue without widening the reset net.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      // A pop in the same cycle does not rescue a write that saw a full queue.
      ovf_q <= tx_write && full;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame image: everything after the start bit, LSB goes out first
  // ---------------------------------------------------------------------------
  logic [SHIFT_W-1:0] frame_load;

`ifdef SPART_TX_PARITY_EN
  assign frame_load = {{STOP_BITS{1'b1}}, (^head) ^ parity_odd, head};
`else
  logic unused_parity_odd;
  assign unused_parity_odd = parity_odd;
  assign frame_load        = {{STOP_BITS{1'b1}}, head};
`endif

  // ---------------------------------------------------------------------------
  // Serialiser FSM
  // ---------------------------------------------------------------------------
  state_t             state_q, state_d;
  logic [TICK_W-1:0]  tick_q,  tick_d;
  logic [BIT_W-1:0]   bit_q,   bit_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic               tx_q,    tx_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '1;
      tx_q    <= 1'b1;
    end else begin
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = frame_load;
          tick_d  = '0;
          bit_d   = '0;
          state_d = S_ALIGN;
        end
      end

      // The start bit is launched on a tick so it lasts a full bit period.
      S_ALIGN: begin
        if (enable) begin
          tx_d    = 1'b0;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (enable) begin
          if (tick_q != TICK_LAST) begin
            tick_d = tick_q + 1'b1;
          end else begin
            tick_d = '0;
            if (bit_q != BIT_LAST) begin
              tx_d    = shift_q[0];
              shift_d = {1'b1, shift_q[SHIFT_W-1:1]};
              bit_d   = bit_q + 1'b1;
            end else if (count_q != '0) begin
              // Last stop bit done with work queued: next start bit right away.
              pop     = 1'b1;
              shift_d = frame_load;
              bit_d   = '0;
              tx_d    = 1'b0;
            end else begin
              tx_d    = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign TBR         = !full;
  assign tx_busy     = (state_q != S_IDLE) || (count_q != '0);
  assign fifo_count  = count_q;
  assign tx_overflow = ovf_q;
  assign TX          = tx_q;

endmodule

// File: tb/tb_spart_tx_fifo.sv
// Randomised scoreboard bench for spart_tx_fifo: queue/timing reference model plus
// a tick-level TX line decoder. Honours SPART_TX_PARITY_EN when defined.
module tb_spart_tx_fifo;

  localparam int DATA_W     = 8;
  localparam int OVERSAMPLE = 16;
  localparam int STOP_BITS  = 1;
  localparam int FIFO_DEPTH = 4;
`ifdef SPART_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int FRAME_BITS  = 1 + DATA_W + PAR_BITS + STOP_BITS;
  localparam int FRAME_TICKS = FRAME_BITS * OVERSAMPLE;
  localparam int CNT_W       = $clog2(FIFO_DEPTH) + 1;

  typedef logic [15:0] frame_t;

  logic              clk        = 1'b0;
  logic              rst_n      = 1'b0;
  logic              enable     = 1'b0;
  logic              tx_write   = 1'b0;
  logic [DATA_W-1:0] tx_data    = '0;
  logic              parity_odd = 1'b0;
  logic              TBR;
  logic              tx_busy;
  logic [CNT_W-1:0]  fifo_count;
  logic              tx_overflow;
  logic              TX;

  spart_tx_fifo #(
    .DATA_W     (DATA_W),
    .OVERSAMPLE (OVERSAMPLE),
    .STOP_BITS  (STOP_BITS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .tx_write    (tx_write),
    .tx_data     (tx_data),
    .parity_odd  (parity_odd),
    .TBR         (TBR),
    .tx_busy     (tx_busy),
    .fifo_count  (fifo_count),
    .tx_overflow (tx_overflow),
    .TX          (TX)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // 0: tick every cycle, 1: every third cycle, 2: random, 3: no ticks
  int en_mode = 0;

  initial begin
    int en_div;
    en_div = 0;
    forever begin
      @(posedge clk);
      #2;
      case (en_mode)
        0: enable = 1'b1;
        1: begin
          enable = (en_div == 0);
          en_div = (en_div + 1) % 3;
        end
        2: enable = ($urandom_range(0, 2) == 0);
        default: enable = 1'b0;
      endcase
    end
  end

  // Expected line image of one frame, bit 0 first; unused upper bits stay 1.
  function automatic frame_t build_frame(input logic [DATA_W-1:0] d, input logic po);
    frame_t f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < DATA_W; i++) f[1 + i] = d[i];
    if (PAR_BITS == 1) f[1 + DATA_W] = (^d) ^ po;
    return f;
  endfunction

  // Reference model state: queue contents and frame progress in ticks.
  logic [DATA_W-1:0] m_q[$];
  int     m_act  = 0;        // 0 idle, 1 waiting for first tick, 2 sending
  int     m_left = 0;        // ticks until the current frame completes
  bit     exp_ovf = 1'b0;
  frame_t exp_frames[$];

  // Line decoder state
  bit     mon_busy = 1'b0;
  frame_t mon_exp;
  frame_t mon_rx;
  int     mon_idx = 0;
  int     mon_bad = 0;
  int     idle_ticks = 0;
  int     frames_done = 0;
  int     ovf_seen = 0;
  int     gap_log[$];
  longint edge_log[$];
  longint cyc = 0;
  logic   prev_tx = 1'b1;

  always @(posedge clk) begin : model_and_monitor
    logic              en_s, wr_s, po_s;
    logic [DATA_W-1:0] d_s;
    int                cnt_before, b;
    en_s = enable;
    wr_s = tx_write;
    po_s = parity_odd;
    d_s  = tx_data;
    cyc++;

    if (!rst_n) begin
      m_q.delete();
      exp_frames.delete();
      m_act   = 0;
      m_left  = 0;
      exp_ovf = 1'b0;
    end else begin
      cnt_before = m_q.size();
      exp_ovf    = wr_s && (cnt_before >= FIFO_DEPTH);
      if (m_act == 0) begin
        if (cnt_before != 0) begin
          exp_frames.push_back(build_frame(m_q.pop_front(), po_s));
          m_act = 1;
        end
      end else if (m_act == 1) begin
        if (en_s) begin
          m_act  = 2;
          m_left = FRAME_TICKS;
        end
      end else if (en_s) begin
        m_left--;
        if (m_left == 0) begin
          if (cnt_before != 0) begin
            exp_frames.push_back(build_frame(m_q.pop_front(), po_s));
            m_left = FRAME_TICKS;
          end else begin
            m_act = 0;
          end
        end
      end
      if (wr_s && cnt_before < FIFO_DEPTH) m_q.push_back(d_s);
    end

    #1;
    if (!rst_n) begin
      mon_busy   = 1'b0;
      idle_ticks = 0;
      prev_tx    = TX;
    end else begin
      check("fifo_count", 32'(fifo_count), 32'(m_q.size()));
      check("TBR", 32'(TBR), 32'(m_q.size() < FIFO_DEPTH));
      check("tx_busy", 32'(tx_busy), 32'((m_act != 0) || (m_q.size() != 0)));
      check("tx_overflow", 32'(tx_overflow), 32'(exp_ovf));
      if (tx_overflow === 1'b1) ovf_seen++;
      if (TX !== prev_tx) edge_log.push_back(cyc);

      if (!en_s) begin
        check("tx_hold_without_tick", 32'(TX), 32'(prev_tx));
      end else begin
        if (!mon_busy) begin
          if (TX === 1'b0) begin
            if (exp_frames.size() == 0) begin
              check("unexpected_start", 32'd1, 32'd0);
            end else begin
              mon_exp  = exp_frames.pop_front();
              mon_rx   = '1;
              mon_busy = 1'b1;
              mon_idx  = 0;
              mon_bad  = 0;
              gap_log.push_back(idle_ticks);
              idle_ticks = 0;
            end
          end else begin
            idle_ticks++;
          end
        end
        if (mon_busy) begin
          b = mon_idx / OVERSAMPLE;
          if (TX !== mon_exp[b]) mon_bad++;
          if (mon_idx % OVERSAMPLE == OVERSAMPLE / 2) mon_rx[b] = TX;
          mon_idx++;
          if (mon_idx == FRAME_TICKS) begin
            check("frame_bits", 32'(mon_rx), 32'(mon_exp));
            check("frame_bad_ticks", 32'(mon_bad), 32'd0);
            mon_busy = 1'b0;
            frames_done++;
          end
        end
      end
      prev_tx = TX;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [DATA_W-1:0] d);
    tx_write = 1'b1;
    tx_data  = d;
    step();
    tx_write = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((m_act != 0 || m_q.size() != 0 || mon_busy || exp_frames.size() != 0) && n < budget) begin
      step();
      n++;
    end
    check("drain_within_budget", 32'(n < budget), 32'd1);
  endtask

  task automatic wait_sample(input int idx, input int budget);
    int n;
    n = 0;
    while (!(mon_busy && mon_idx >= idx) && n < budget) begin
      step();
      n++;
    end
    check("reach_frame_point", 32'(n < budget), 32'd1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin : stimulus
    int     gsz, e0, f0, ov0, nexp;
    int     exp_edges[$];
    frame_t f;
    logic   tx_before;

    // Reset values while rst_n is held low
    repeat (3) step();
    check("rst_TX", 32'(TX), 32'd1);
    check("rst_TBR", 32'(TBR), 32'd1);
    check("rst_tx_busy", 32'(tx_busy), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_tx_overflow", 32'(tx_overflow), 32'd0);
    rst_n = 1'b1;
    repeat (2) step();

    // Single frame, then back to idle
    en_mode = 0;
    push(8'hA5);
    wait_drain(2000);
    check("idle_busy_after_A5", 32'(tx_busy), 32'd0);
    check("idle_TX_after_A5", 32'(TX), 32'd1);

    // Parity cases (frame image includes parity only when enabled)
    parity_odd = 1'b0;
    push(8'hA5);
    wait_drain(2000);
    push(8'h07);
    wait_drain(2000);
    parity_odd = 1'b1;
    push(8'h07);
    wait_drain(2000);
    parity_odd = 1'b0;

    // Six consecutive writes into an idle block with a 4-entry queue
    gsz = gap_log.size();
    ov0 = ovf_seen;
    for (int i = 0; i < 6; i++) push(DATA_W'(8'h11 * (i + 1)));
    check("burst_fifo_count", 32'(fifo_count), 32'(FIFO_DEPTH));
    check("burst_TBR", 32'(TBR), 32'd0);
    wait_drain(4000);
    check("burst_overflow_pulses", 32'(ovf_seen - ov0), 32'd1);
    check("burst_frames", 32'(gap_log.size() - gsz), 32'd5);
    for (int i = 1; i < 5; i++) begin
      if (gsz + i < gap_log.size()) check("burst_back_to_back_gap", 32'(gap_log[gsz + i]), 32'd0);
    end

    // Tick every third cycle: each bit period is 3*OVERSAMPLE clocks
    en_mode = 1;
    repeat (5) step();
    e0 = edge_log.size();
    f  = build_frame(8'h55, parity_odd);
    exp_edges.delete();
    exp_edges.push_back(0);
    for (int k = 1; k < FRAME_BITS; k++) begin
      if (f[k] != f[k - 1]) exp_edges.push_back(k);
    end
    push(8'h55);
    wait_drain(3 * FRAME_TICKS + 200);
    nexp = exp_edges.size();
    check("slow_tick_edge_count", 32'(edge_log.size() - e0), 32'(nexp));
    for (int j = 1; j < nexp; j++) begin
      if (e0 + j < edge_log.size())
        check("slow_tick_edge_spacing", 32'(edge_log[e0 + j] - edge_log[e0]),
              32'(exp_edges[j] * 3 * OVERSAMPLE));
    end

    // Ticks stop mid-frame: the line must hold its bit
    en_mode = 0;
    push(8'h3C);
    wait_sample(3 * OVERSAMPLE + 2, 500);
    en_mode = 3;
    step();
    tx_before = TX;
    repeat (200) step();
    check("stall_holds_bit", 32'(TX), 32'(tx_before));
    en_mode = 0;
    wait_drain(2000);

    // Reset during data bit 4 with two words queued
    push(8'hC3);
    push(8'h5A);
    push(8'h96);
    wait_sample(5 * OVERSAMPLE + OVERSAMPLE / 2, 500);
    check("pre_reset_queued", 32'(fifo_count), 32'd2);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_TX", 32'(TX), 32'd1);
    check("async_rst_fifo_count", 32'(fifo_count), 32'd0);
    check("async_rst_TBR", 32'(TBR), 32'd1);
    check("async_rst_tx_busy", 32'(tx_busy), 32'd0);
    repeat (3) step();
    rst_n = 1'b1;
    f0 = frames_done;
    e0 = edge_log.size();
    repeat (3 * FRAME_TICKS) step();
    check("no_frames_after_reset", 32'(frames_done - f0), 32'd0);
    check("no_tx_edges_after_reset", 32'(edge_log.size() - e0), 32'd0);

    // Randomised traffic with irregular ticks and per-cycle parity changes
    en_mode = 2;
    for (int c = 0; c < 2500; c++) begin
      tx_write   = ($urandom_range(0, 5) == 0);
      tx_data    = DATA_W'($urandom);
      parity_odd = 1'(($urandom));
      step();
    end
    tx_write = 1'b0;
    wait_drain(8000);
    check("random_all_frames_seen", 32'(exp_frames.size()), 32'd0);
    check("final_idle_TX", 32'(TX), 32'd1);
    check("final_idle_busy", 32'(tx_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
